i2s_audio_tx: RTL and testbench

- Downstream stage of the stereo note generator.
- Takes the 16-bit left/right audio samples it produces and serialises them to an I2S DAC (Pmod I2S2-style) as MCLK, LRCK, SCK and SDIN.
- Everything is derived from one free-running 9-bit frame counter on the 100 MHz clk: MCLK = clk/4, SCK = clk/8, LRCK = clk/512 (~195 kHz frame).
- Left/right samples are captured coherently once per frame. A per-frame tick is provided so upstream logic can align sample updates.

---
 rtl/i2s_audio_tx_if.sv | 25 ++
 rtl/i2s_audio_tx.sv | 59 +++++
 tb/tb_i2s_audio_tx.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/i2s_audio_tx_if.sv
// Sample inputs and I2S pin outputs of the audio transmitter.
interface i2s_audio_tx_if #(
    parameter int unsigned DATA_W = 16
);
    logic [DATA_W-1:0] audio_left;
    logic [DATA_W-1:0] audio_right;
    logic              mute;
    logic              audio_mclk;
    logic              audio_lrck;
    logic              audio_sck;
    logic              audio_sdin;
    logic              sample_tick;

    // Upstream sample source: drives samples, observes pins and the frame tick.
    modport master (
        output audio_left, audio_right, mute,
        input  audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_tick
    );

    // Transmitter side.
    modport slave (
        input  audio_left, audio_right, mute,
        output audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_tick
    );
endinterface

// File: rtl/i2s_audio_tx.sv
// I2S transmitter: one free-running 9-bit frame counter yields MCLK (clk/4), SCK (clk/8) and
// LRCK (clk/512); stereo samples are captured together once per frame and shifted out MSB
// first with the standard one-slot I2S delay.
module i2s_audio_tx #(
    parameter int unsigned DATA_W = 16
) (
    input logic           clk,
    input logic           rst,
    i2s_audio_tx_if.slave bus
);
    logic [8:0]        cnt_q;
    logic [8:0]        cnt_d;
    logic [DATA_W-1:0] hold_left_q;
    logic [DATA_W-1:0] hold_right_q;
    logic              sdin_q;
    logic              sdin_d;
    logic              frame_end;
    logic [4:0]        slot;
    logic [31:0]       half_word;

    assign cnt_d     = cnt_q + 9'd1;
    assign frame_end = &cnt_q;
    // SDIN is prepared one cycle early, so the slot is taken from the upcoming count.
    assign slot      = cnt_d[7:3];

    // Lay out one half-frame as 32 slots (slot 0 in bit 31) and pick the upcoming slot's bit;
    // only refresh on the cycle that ends in an SCK falling edge.
    always_comb begin
        half_word = '0;
        half_word[30 -: DATA_W] = cnt_d[8] ? hold_right_q : hold_left_q;
        sdin_d = sdin_q;
        if (cnt_d[2:0] == 3'b000) begin
            sdin_d = half_word[~slot];
        end
    end

    // Frame counter, coherent stereo capture at frame end, and the registered SDIN bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            hold_left_q  <= '0;
            hold_right_q <= '0;
            sdin_q       <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sdin_q <= sdin_d;
            if (frame_end) begin
                hold_left_q  <= bus.mute ? '0 : bus.audio_left;
                hold_right_q <= bus.mute ? '0 : bus.audio_right;
            end
        end
    end

    assign bus.audio_mclk  = cnt_q[1];
    assign bus.audio_sck   = cnt_q[2];
    assign bus.audio_lrck  = cnt_q[8];
    assign bus.audio_sdin  = sdin_q;
    assign bus.sample_tick = frame_end;
endmodule

// File: tb/tb_i2s_audio_tx.sv
// Self-checking bench for i2s_audio_tx: a cycle-count reference model predicts every pin each
// cycle, and directed frames are checked as 32-bit words gathered on SCK rising edges.
module tb_i2s_audio_tx;
    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    logic rst;

    i2s_audio_tx_if #(.DATA_W(DW)) bus ();

    i2s_audio_tx #(.DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: cycles elapsed since reset plus the samples for the frame in flight.
    int unsigned   mcnt;
    logic [DW-1:0] cur_l;
    logic [DW-1:0] cur_r;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt  <= 0;
            cur_l <= '0;
            cur_r <= '0;
        end else begin
            if (mcnt % 512 == 511) begin
                cur_l <= bus.mute ? '0 : bus.audio_left;
                cur_r <= bus.mute ? '0 : bus.audio_right;
            end
            mcnt <= mcnt + 1;
        end
    end

    int          checks = 0;
    int          failures = 0;
    int          tick_count = 0;
    logic        prev_sdin = 1'b0;
    logic [31:0] shreg = '0;
    logic [31:0] last_left = '0;
    logic [31:0] last_right = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_sdin(input int unsigned p);
        int unsigned   k;
        logic [DW-1:0] s;
        k = (p % 256) / 8;
        s = (p >= 256) ? cur_r : cur_l;
        if (k >= 1 && k <= DW) return s[DW-k];
        return 1'b0;
    endfunction

    // One clock: sample at the falling edge and compare every pin against the model.
    task automatic step();
        int unsigned p;
        @(negedge clk);
        p = mcnt % 512;
        chk("mclk", 32'(bus.audio_mclk), 32'((p / 2) % 2));
        chk("sck", 32'(bus.audio_sck), 32'((p / 4) % 2));
        chk("lrck", 32'(bus.audio_lrck), 32'(p / 256));
        chk("tick", 32'(bus.sample_tick), 32'(p == 511));
        chk("sdin", 32'(bus.audio_sdin), 32'(exp_sdin(p)));
        if (p % 8 != 0) chk("sdin_stable", 32'(bus.audio_sdin), 32'(prev_sdin));
        prev_sdin = bus.audio_sdin;
        if (bus.sample_tick === 1'b1) tick_count++;
        if (p % 8 == 4) begin
            shreg = {shreg[30:0], bus.audio_sdin};
            if (p == 252) last_left = shreg;
            if (p == 508) last_right = shreg;
        end
    endtask

    task automatic wait_phase(input int unsigned target);
        int n = 0;
        do begin
            step();
            n++;
        end while (mcnt % 512 != target && n < 1100);
        chk("wait_bound", 32'(n < 1100), 32'd1);
    endtask

    function automatic logic [31:0] word_of(input logic [DW-1:0] s);
        logic [31:0] w;
        w = '0;
        w[30 -: DW] = s;
        return w;
    endfunction

    logic [DW-1:0] rl;
    logic [DW-1:0] rr;
    logic [31:0]   exp_l;
    logic [31:0]   exp_r;

    initial begin
        rst = 1'b1;
        bus.audio_left  = '0;
        bus.audio_right = '0;
        bus.mute        = 1'b0;
        repeat (3) step();
        chk("rst_sdin", 32'(bus.audio_sdin), 32'd0);
        chk("rst_lrck", 32'(bus.audio_lrck), 32'd0);
        #1 rst = 1'b0;
        bus.audio_left  = 16'hA5C3;
        bus.audio_right = 16'h0F0F;

        // Frame 0 after reset carries zeros.
        wait_phase(510);
        chk("f0_left", last_left, 32'h0);
        chk("f0_right", last_right, 32'h0);
        chk("f0_ticks", 32'(tick_count), 32'd0);

        // Frame 1 carries A5C3/0F0F; a mid-frame input change must not leak in.
        wait_phase(100);
        #1 bus.audio_left = 16'hFFFF;
        wait_phase(510);
        chk("f1_left", last_left, 32'h52E1_8000);
        chk("f1_right", last_right, 32'h0787_8000);
        wait_phase(511);
        chk("ticks_1024", 32'(tick_count), 32'd2);

        // Frame 2 shows the mid-frame change; then a muted capture.
        wait_phase(510);
        chk("f2_left", last_left, 32'h7FFF_8000);
        chk("f2_right", last_right, 32'h0787_8000);
        #1;
        bus.audio_left  = 16'h7FFF;
        bus.audio_right = 16'h8000;
        bus.mute        = 1'b1;
        wait_phase(0);
        #1 bus.mute = 1'b0;
        wait_phase(510);
        chk("mute_left", last_left, 32'h0);
        chk("mute_right", last_right, 32'h0);
        wait_phase(510);
        chk("unmute_left", last_left, 32'h3FFF_8000);
        chk("unmute_right", last_right, 32'h4000_0000);

        // Reset while right-channel bits are shifting.
        wait_phase(300);
        #1 rst = 1'b1;
        #1;
        chk("arst_mclk", 32'(bus.audio_mclk), 32'd0);
        chk("arst_sck", 32'(bus.audio_sck), 32'd0);
        chk("arst_lrck", 32'(bus.audio_lrck), 32'd0);
        chk("arst_sdin", 32'(bus.audio_sdin), 32'd0);
        chk("arst_tick", 32'(bus.sample_tick), 32'd0);
        repeat (3) step();
        #1 rst = 1'b0;
        step();
        chk("restart_cnt", mcnt, 32'd1);
        chk("restart_mclk", 32'(bus.audio_mclk), 32'd0);
        wait_phase(510);
        chk("rec_left", last_left, 32'h0);
        chk("rec_right", last_right, 32'h0);

        // Random samples over several frames, with ignored mid-frame perturbation.
        exp_l = '0;
        exp_r = '0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                chk("rnd_left", last_left, exp_l);
                chk("rnd_right", last_right, exp_r);
            end
            rl = DW'($urandom);
            rr = DW'($urandom);
            #1;
            bus.audio_left  = rl;
            bus.audio_right = rr;
            exp_l = word_of(rl);
            exp_r = word_of(rr);
            wait_phase(100);
            #1;
            bus.audio_left  = DW'($urandom);
            bus.audio_right = DW'($urandom);
            wait_phase(510);
            #1;
            bus.audio_left  = rl;
            bus.audio_right = rr;
            wait_phase(100);
            #1;
            bus.audio_left  = DW'($urandom);
            bus.audio_right = DW'($urandom);
            wait_phase(510);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
